// File: rtl/msi_pkg.sv
// Shared types and constants for the MSI main-memory controller.
// Bus message encoding, controller states and the reset line pattern.
package msi_pkg;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_RDX  = 2'b01,
    BUS_UPGR = 2'b10,
    BUS_RSVD = 2'b11
  } bus_msg_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } mem_state_t;

  // 16-bit word replicated across every line at reset
  localparam logic [15:0] INIT_LINE = 16'hCAFE;

endpackage

// File: rtl/msi_mem_array.sv
// Backing store: one sync write port, one async read port.
// Every line resets to the replicated INIT_LINE word.
module msi_mem_array
  import msi_pkg::*;
#(
  parameter int CACHE_LINE_SIZE = 128,
  parameter int NUM_MEM_LINES   = 16,
  parameter int IDX_W           = $clog2(NUM_MEM_LINES)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       we_i,
  input  logic [IDX_W-1:0]           waddr_i,
  input  logic [CACHE_LINE_SIZE-1:0] wdata_i,
  input  logic [IDX_W-1:0]           raddr_i,
  output logic [CACHE_LINE_SIZE-1:0] rdata_o
);

  localparam logic [CACHE_LINE_SIZE-1:0] RST_LINE =
    {(CACHE_LINE_SIZE/16){INIT_LINE}};

  logic [CACHE_LINE_SIZE-1:0] mem_q [NUM_MEM_LINES];

  // Line storage with reset to the init pattern
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_MEM_LINES; i++) begin
        mem_q[i] <= RST_LINE;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/msi_mem_ctrl.sv
// MSI main-memory controller: fixed-latency line reads, flush absorb.
// Optional MSI_MEM_STATS_EN adds saturating rd/rdx/flush counters.
module msi_mem_ctrl
  import msi_pkg::*;
#(
  parameter int ADDR_SIZE       = 32,
  parameter int CACHE_LINE_SIZE = 128,
  parameter int NUM_MEM_LINES   = 16,
  parameter int MEM_LATENCY     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       bus_valid_i,
  input  logic [1:0]                 bus_msg_i,
  input  logic [ADDR_SIZE-1:0]       bus_addr_i,
  input  logic                       flush_i,
  input  logic [CACHE_LINE_SIZE-1:0] flush_data_i,
  output logic [CACHE_LINE_SIZE-1:0] mem_data_o,
  output logic                       mem_valid_o,
  output logic                       mem_busy_o,
  output logic                       err_o
`ifdef MSI_MEM_STATS_EN
  ,
  output logic [15:0]                stat_rd_o,
  output logic [15:0]                stat_rdx_o,
  output logic [15:0]                stat_flush_o
`endif
);

  localparam int OFF   = $clog2(CACHE_LINE_SIZE/8);
  localparam int IDX_W = $clog2(NUM_MEM_LINES);

  mem_state_t state_q;
  logic [3:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic err_q;

  bus_msg_t msg;
  logic [IDX_W-1:0] idx;
  logic is_rd, accept, wr_en, err_set;
  logic [CACHE_LINE_SIZE-1:0] rd_data;
  logic unused_addr;

  assign msg = bus_msg_t'(bus_msg_i);
  assign idx = bus_addr_i[OFF+IDX_W-1:OFF];
  assign unused_addr = ^bus_addr_i;

  assign is_rd = bus_valid_i && !flush_i &&
                 (msg == BUS_RD || msg == BUS_RDX);
  assign accept = is_rd && (state_q == IDLE);
  assign wr_en = bus_valid_i && flush_i;
  assign err_set = (bus_valid_i && msg == BUS_RSVD) ||
                   (is_rd && state_q != IDLE) ||
                   (flush_i && !bus_valid_i);

  msi_mem_array #(
    .CACHE_LINE_SIZE(CACHE_LINE_SIZE),
    .NUM_MEM_LINES  (NUM_MEM_LINES),
    .IDX_W          (IDX_W)
  ) u_array (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (wr_en),
    .waddr_i(idx),
    .wdata_i(flush_data_i),
    .raddr_i(idx_q),
    .rdata_o(rd_data)
  );

  // Request FSM: cnt_q counts WAIT cycles left before RESP
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_q | err_set;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q <= idx;
            if (MEM_LATENCY == 1) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(MEM_LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data is read in the RESP cycle so late flushes are seen
  assign mem_valid_o = (state_q == RESP);
  assign mem_busy_o  = (state_q != IDLE);
  assign mem_data_o  = mem_valid_o ? rd_data : '0;
  assign err_o       = err_q;

`ifdef MSI_MEM_STATS_EN
  logic [15:0] rd_cnt_q, rdx_cnt_q, fl_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q  <= '0;
      rdx_cnt_q <= '0;
      fl_cnt_q  <= '0;
    end else begin
      if (accept && msg == BUS_RD && rd_cnt_q != 16'hFFFF)
        rd_cnt_q <= rd_cnt_q + 16'd1;
      if (accept && msg == BUS_RDX && rdx_cnt_q != 16'hFFFF)
        rdx_cnt_q <= rdx_cnt_q + 16'd1;
      if (wr_en && fl_cnt_q != 16'hFFFF)
        fl_cnt_q <= fl_cnt_q + 16'd1;
    end
  end

  assign stat_rd_o    = rd_cnt_q;
  assign stat_rdx_o   = rdx_cnt_q;
  assign stat_flush_o = fl_cnt_q;
`endif

endmodule

// File: tb/tb_msi_mem_ctrl.sv
// Scoreboard bench for msi_mem_ctrl at default parameters.
module tb_msi_mem_ctrl;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         bus_valid_i;
  logic [1:0]   bus_msg_i;
  logic [31:0]  bus_addr_i;
  logic         flush_i;
  logic [127:0] flush_data_i;
  logic [127:0] mem_data_o;
  logic         mem_valid_o;
  logic         mem_busy_o;
  logic         err_o;
`ifdef MSI_MEM_STATS_EN
  logic [15:0]  stat_rd_o, stat_rdx_o, stat_flush_o;
`endif

  msi_mem_ctrl #(
    .ADDR_SIZE      (32),
    .CACHE_LINE_SIZE(128),
    .NUM_MEM_LINES  (16),
    .MEM_LATENCY    (LAT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .bus_valid_i (bus_valid_i),
    .bus_msg_i   (bus_msg_i),
    .bus_addr_i  (bus_addr_i),
    .flush_i     (flush_i),
    .flush_data_i(flush_data_i),
    .mem_data_o  (mem_data_o),
    .mem_valid_o (mem_valid_o),
    .mem_busy_o  (mem_busy_o),
    .err_o       (err_o)
`ifdef MSI_MEM_STATS_EN
    ,
    .stat_rd_o   (stat_rd_o),
    .stat_rdx_o  (stat_rdx_o),
    .stat_flush_o(stat_flush_o)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [1:0] RD = 2'b00, RDX = 2'b01;
  localparam logic [1:0] UPGR = 2'b10, RSVD = 2'b11;
  localparam logic [127:0] CAFE = {8{16'hCAFE}};

  int n_chk = 0;
  int n_err = 0;
  int n_resp = 0;
  logic [127:0] exp_q [$];
  logic [127:0] mdl [16];

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lidx(input logic [31:0] a);
    return int'(a[7:4]);
  endfunction

  // Response monitor: pops scoreboard on every valid pulse
  always @(negedge clk) begin
    if (mem_valid_o) begin
      n_resp++;
      if (exp_q.size() == 0)
        check("unexpected_resp", 128'(mem_valid_o), 128'(0));
      else
        check("rdata", mem_data_o, exp_q.pop_front());
    end
  end

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = CAFE;
  endtask

  // Drive one bus cycle, sampled at the next posedge
  task automatic req(input logic [1:0] m, input logic [31:0] a,
                     input logic fl, input logic [127:0] d);
    bus_valid_i = 1'b1;
    bus_msg_i = m;
    bus_addr_i = a;
    flush_i = fl;
    flush_data_i = d;
    if (fl) mdl[lidx(a)] = d;
    else if (m == RD || m == RDX) exp_q.push_back(mdl[lidx(a)]);
    @(posedge clk);
    #1;
    bus_valid_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      @(negedge clk);
    check(tag, 128'(exp_q.size()), 128'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  int r0;

  initial begin
    rst_i = 1'b1;
    bus_valid_i = 1'b0;
    bus_msg_i = RD;
    bus_addr_i = '0;
    flush_i = 1'b0;
    flush_data_i = '0;
    do_reset();

    @(negedge clk);
    check("rst_valid", 128'(mem_valid_o), 128'(0));
    check("rst_busy", 128'(mem_busy_o), 128'(0));
    check("rst_err", 128'(err_o), 128'(0));
    check("rst_data", mem_data_o, 128'(0));
    @(posedge clk); #1;

    // Read timing: busy for LAT cycles, pulse in the last
    req(RD, 32'h20, 1'b0, '0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      check($sformatf("t1_busy%0d", k), 128'(mem_busy_o), 128'(1));
      check($sformatf("t1_valid%0d", k), 128'(mem_valid_o),
            128'(k == LAT));
    end
    @(negedge clk);
    check("t1_idle", 128'(mem_busy_o), 128'(0));
    check("t1_data0", mem_data_o, 128'(0));
    drain("t1_drain");

    // Flush then read back the flushed line
    req(RD, 32'h30, 1'b1, 128'h1234);
    @(negedge clk);
    check("t2_nobusy", 128'(mem_busy_o), 128'(0));
    check("t2_noerr", 128'(err_o), 128'(0));
    @(posedge clk); #1;
    req(RDX, 32'h30, 1'b0, '0);
    drain("t2_drain");

    // Flush to the pending line lands before RESP
    req(RD, 32'h10, 1'b0, '0);
    void'(exp_q.pop_back());
    exp_q.push_back(128'hBEEF);
    @(posedge clk); #1;
    req(RD, 32'h10, 1'b1, 128'hBEEF);
    drain("t3_drain");
    check("t3_noerr", 128'(err_o), 128'(0));

    // Second read while busy is dropped and flagged
    r0 = n_resp;
    req(RD, 32'h40, 1'b0, '0);
    bus_valid_i = 1'b1; bus_msg_i = RD; bus_addr_i = 32'h50;
    @(posedge clk); #1;
    bus_valid_i = 1'b0;
    @(negedge clk);
    check("t4_err", 128'(err_o), 128'(1));
    drain("t4_drain");
    check("t4_one_resp", 128'(n_resp - r0), 128'(1));
    req(UPGR, 32'h40, 1'b0, '0);
    @(negedge clk);
    check("t4_upgr_busy", 128'(mem_busy_o), 128'(0));
    repeat (LAT + 2) @(negedge clk);
    check("t4_upgr_resp", 128'(n_resp - r0), 128'(1));
    check("t4_err_sticky", 128'(err_o), 128'(1));
    @(posedge clk); #1;

    // Reset mid-transaction aborts the read
    r0 = n_resp;
    bus_valid_i = 1'b1; bus_msg_i = RD; bus_addr_i = 32'h60;
    @(posedge clk); #1;
    bus_valid_i = 1'b0;
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("t5_valid", 128'(mem_valid_o), 128'(0));
    check("t5_busy", 128'(mem_busy_o), 128'(0));
    check("t5_err", 128'(err_o), 128'(0));
    check("t5_data", mem_data_o, 128'(0));
    repeat (LAT + 2) @(negedge clk);
    check("t5_no_resp", 128'(n_resp - r0), 128'(0));
    @(posedge clk); #1;
    req(RD, 32'h30, 1'b0, '0);
    drain("t5_reinit");

    // Flush without valid is an error
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_noval_err", 128'(err_o), 128'(1));
    @(posedge clk); #1;
    do_reset();

    // Reserved message is an error
    req(RSVD, 32'h0, 1'b0, '0);
    @(negedge clk);
    check("rsvd_err", 128'(err_o), 128'(1));
    check("rsvd_busy", 128'(mem_busy_o), 128'(0));
    @(posedge clk); #1;
    do_reset();

    // Upper address bits alias to the same line
    req(RD, 32'h30, 1'b1, 128'hA5A5);
    req(RDX, 32'h1030, 1'b0, '0);
    drain("alias_drain");
    req(RD, 32'hF0, 1'b0, '0);
    drain("top_line_drain");

`ifdef MSI_MEM_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req(RD, 32'(i * 16), 1'b0, '0);
      drain("st_rd_drain");
    end
    for (int i = 0; i < 2; i++) begin
      req(RDX, 32'(i * 16), 1'b0, '0);
      drain("st_rdx_drain");
    end
    req(RD, 32'h70, 1'b1, 128'h77);
    @(negedge clk);
    check("stat_rd", 128'(stat_rd_o), 128'(3));
    check("stat_rdx", 128'(stat_rdx_o), 128'(2));
    check("stat_flush", 128'(stat_flush_o), 128'(1));
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
